// File: rtl/gcm_decrypt_verify.sv
// rtl/gcm_decrypt_verify.sv - AES-GCM receive side: CTR decrypt, bit-serial GHASH, tag check
module gcm_decrypt_verify (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [127:0] i_h,
    input  logic [127:0] i_encrypted_j0,
    input  logic [127:0] i_tag,
    input  logic [15:0]  i_aad_blocks,
    input  logic [15:0]  i_ct_blocks,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    input  logic [127:0] i_keystream,
    output logic         o_valid,
    output logic [127:0] o_plain_text,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tag_ok
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BLK, S_MULT, S_LEN, S_FINAL, S_DONE
    } state_t;

    // GCM reduction constant; vectors are stored with GCM bit 0 at vector bit 127
    localparam logic [127:0] GF_R = 128'hE1000000_00000000_00000000_00000000;

    state_t        state_q, state_d;
    logic [127:0]  h_q, h_d, ej0_q, ej0_d, tag_q, tag_d;
    logic [15:0]   aad_q, aad_d, ct_q, ct_d;
    logic [16:0]   blk_q, blk_d;
    logic [127:0]  y_q, y_d, x_q, x_d, z_q, z_d, v_q, v_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          len_q, len_d, fin_q, fin_d;
    logic [127:0]  ctag_q, ctag_d;
    logic          tag_ok_q, tag_ok_d, valid_q, valid_d;
    logic [127:0]  pt_q, pt_d;

    logic [16:0]   total_q, total_in;
    logic [127:0]  z_step, v_step;

    assign total_q  = {1'b0, aad_q} + {1'b0, ct_q};
    assign total_in = {1'b0, i_aad_blocks} + {1'b0, i_ct_blocks};

    // One GF(2^128) multiply iteration; GCM bit i lives at vector bit 127-i (= ~cnt)
    always_comb begin
        z_step = x_q[~cnt_q] ? (z_q ^ v_q) : z_q;
        v_step = v_q[0] ? ((v_q >> 1) ^ GF_R) : (v_q >> 1);
    end

    // Next-state and datapath updates for the message sequencer
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        ej0_d    = ej0_q;
        tag_d    = tag_q;
        aad_d    = aad_q;
        ct_d     = ct_q;
        blk_d    = blk_q;
        y_d      = y_q;
        x_d      = x_q;
        z_d      = z_q;
        v_d      = v_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        fin_d    = fin_q;
        ctag_d   = ctag_q;
        tag_ok_d = tag_ok_q;
        valid_d  = 1'b0;
        pt_d     = pt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    h_d      = i_h;
                    ej0_d    = i_encrypted_j0;
                    tag_d    = i_tag;
                    aad_d    = i_aad_blocks;
                    ct_d     = i_ct_blocks;
                    blk_d    = 17'd0;
                    y_d      = 128'd0;
                    len_d    = 1'b0;
                    fin_d    = 1'b0;
                    tag_ok_d = 1'b0;
                    state_d  = (total_in != 17'd0) ? S_WAIT_BLK : S_LEN;
                end
            end
            S_WAIT_BLK: begin
                if (i_valid) begin
                    // GHASH always absorbs the ciphertext, never the recovered plaintext
                    if (blk_q >= {1'b0, aad_q}) begin
                        pt_d    = i_data ^ i_keystream;
                        valid_d = 1'b1;
                    end
                    x_d     = y_q ^ i_data;
                    z_d     = 128'd0;
                    v_d     = h_q;
                    cnt_d   = 7'd0;
                    blk_d   = blk_q + 17'd1;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                z_d   = z_step;
                v_d   = v_step;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd127) begin
                    y_d = z_step;
                    if (len_q)
                        state_d = S_FINAL;
                    else if (blk_q == total_q)
                        state_d = S_LEN;
                    else
                        state_d = S_WAIT_BLK;
                end
            end
            S_LEN: begin
                x_d     = y_q ^ {41'd0, aad_q, 7'd0, 41'd0, ct_q, 7'd0};
                z_d     = 128'd0;
                v_d     = h_q;
                cnt_d   = 7'd0;
                len_d   = 1'b1;
                state_d = S_MULT;
            end
            S_FINAL: begin
                // Two cycles: form the computed tag, then register the compare
                if (!fin_q) begin
                    ctag_d = y_q ^ ej0_q;
                    fin_d  = 1'b1;
                end else begin
                    tag_ok_d = (ctag_q == tag_q);
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            ej0_q    <= '0;
            tag_q    <= '0;
            aad_q    <= '0;
            ct_q     <= '0;
            blk_q    <= '0;
            y_q      <= '0;
            x_q      <= '0;
            z_q      <= '0;
            v_q      <= '0;
            cnt_q    <= '0;
            len_q    <= 1'b0;
            fin_q    <= 1'b0;
            ctag_q   <= '0;
            tag_ok_q <= 1'b0;
            valid_q  <= 1'b0;
            pt_q     <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            ej0_q    <= ej0_d;
            tag_q    <= tag_d;
            aad_q    <= aad_d;
            ct_q     <= ct_d;
            blk_q    <= blk_d;
            y_q      <= y_d;
            x_q      <= x_d;
            z_q      <= z_d;
            v_q      <= v_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            fin_q    <= fin_d;
            ctag_q   <= ctag_d;
            tag_ok_q <= tag_ok_d;
            valid_q  <= valid_d;
            pt_q     <= pt_d;
        end
    end

    assign o_ready      = (state_q == S_WAIT_BLK);
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done       = (state_q == S_DONE);
    assign o_tag_ok     = tag_ok_q;
    assign o_valid      = valid_q;
    assign o_plain_text = pt_q;

endmodule

// File: tb/tb_gcm_decrypt_verify.sv
// tb/tb_gcm_decrypt_verify.sv - randomized self-checking bench for gcm_decrypt_verify
module tb_gcm_decrypt_verify;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [127:0] i_h, i_encrypted_j0, i_tag;
    logic [15:0]  i_aad_blocks, i_ct_blocks;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data, i_keystream;
    logic         o_valid;
    logic [127:0] o_plain_text;
    logic         o_busy, o_done, o_tag_ok;

    gcm_decrypt_verify dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_h(i_h),
        .i_encrypted_j0(i_encrypted_j0), .i_tag(i_tag),
        .i_aad_blocks(i_aad_blocks), .i_ct_blocks(i_ct_blocks),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .i_keystream(i_keystream), .o_valid(o_valid), .o_plain_text(o_plain_text),
        .o_busy(o_busy), .o_done(o_done), .o_tag_ok(o_tag_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [127:0] blk_data [8];
    logic [127:0] blk_ks   [8];

    localparam logic [127:0] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] NIST_EJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] TC2_C    = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TC2_TAG  = 128'hab6e47d42cec13bdf53a67b21257bddf;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // GF(2^128) product in GCM bit order (bit 0 = MSB)
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z = '0;
        logic [127:0] v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127 - i]) z ^= v;
            v = v[0] ? ((v >> 1) ^ {8'hE1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    // Expected tag: GHASH over the block list plus the length block, masked by E(K,J0)
    function automatic logic [127:0] model_tag(input logic [127:0] h, input logic [127:0] ej0,
                                               input int na, input int nc);
        logic [127:0] y = '0;
        logic [63:0]  abits = 64'(na) * 64'd128;
        logic [63:0]  cbits = 64'(nc) * 64'd128;
        for (int i = 0; i < na + nc; i++) y = gmul(y ^ blk_data[i], h);
        y = gmul(y ^ {abits, cbits}, h);
        return y ^ ej0;
    endfunction

    task automatic run_msg(input string nm, input logic [127:0] h, input logic [127:0] ej0,
                           input logic [127:0] tag, input int na, input int nc,
                           input logic exp_ok, input logic spam);
        int start_edge, prev, k, guard, nvalid;
        k = 0; guard = 0; nvalid = 0;
        i_h = h; i_encrypted_j0 = ej0; i_tag = tag;
        i_aad_blocks = 16'(na); i_ct_blocks = 16'(nc);
        i_start = 1'b1;
        start_edge = cyc + 1;
        prev = start_edge;
        step();
        i_start = 1'b0;
        chk({nm, ".busy"}, o_busy, 1'b1);
        while (k < na + nc && guard < 2000) begin
            i_valid = 1'b1;
            i_data = blk_data[k];
            i_keystream = blk_ks[k];
            if (o_ready) begin
                if (k > 0) chk({nm, ".spacing"}, cyc + 1 - prev, 129);
                prev = cyc + 1;
                step();
                if (k >= na) begin
                    chk({nm, ".pt_valid"}, o_valid, 1'b1);
                    chk({nm, ".pt"}, o_plain_text, blk_data[k] ^ blk_ks[k]);
                end else begin
                    chk({nm, ".aad_novalid"}, o_valid, 1'b0);
                end
                if (o_valid) nvalid++;
                k++;
            end else begin
                if (spam && (guard % 37) == 5) begin
                    i_start = 1'b1;
                    i_h = rnd128(); i_encrypted_j0 = rnd128(); i_tag = rnd128();
                    i_aad_blocks = 16'($urandom_range(0, 3));
                    i_ct_blocks = 16'($urandom_range(0, 3));
                end
                step();
                i_start = 1'b0;
                if (o_valid) nvalid++;
            end
            guard++;
        end
        i_valid = 1'b0;
        chk({nm, ".blocks_accepted"}, k, na + nc);
        guard = 0;
        while (!o_done && guard < 600) begin
            step();
            if (o_valid) nvalid++;
            guard++;
        end
        chk({nm, ".done"}, o_done, 1'b1);
        if (na + nc > 0) chk({nm, ".latency"}, cyc - prev, 259);
        else chk({nm, ".latency"}, cyc - start_edge, 131);
        chk({nm, ".tag_ok"}, o_tag_ok, exp_ok);
        chk({nm, ".valid_count"}, nvalid, nc);
        chk({nm, ".busy_done"}, o_busy, 1'b0);
        chk({nm, ".ready_done"}, o_ready, 1'b0);
    endtask

    initial begin
        int na, nc;
        logic flip;
        logic [127:0] h, ej0, t;
        rst = 1'b1; i_start = 1'b0; i_valid = 1'b0;
        i_h = '0; i_encrypted_j0 = '0; i_tag = '0;
        i_aad_blocks = '0; i_ct_blocks = '0; i_data = '0; i_keystream = '0;
        step(); step();
        chk("reset.ready", o_ready, 1'b0);
        chk("reset.valid", o_valid, 1'b0);
        chk("reset.pt", o_plain_text, 128'd0);
        chk("reset.busy", o_busy, 1'b0);
        chk("reset.done", o_done, 1'b0);
        chk("reset.tag_ok", o_tag_ok, 1'b0);
        rst = 1'b0;
        step();

        run_msg("tc1", NIST_H, NIST_EJ0, NIST_EJ0, 0, 0, 1'b1, 1'b0);

        blk_data[0] = TC2_C; blk_ks[0] = TC2_C;
        run_msg("tc2", NIST_H, NIST_EJ0, TC2_TAG, 0, 1, 1'b1, 1'b0);
        run_msg("tc2_badtag", NIST_H, NIST_EJ0, TC2_TAG ^ 128'd1, 0, 1, 1'b0, 1'b0);

        h = rnd128(); ej0 = rnd128();
        for (int i = 0; i < 4; i++) begin blk_data[i] = rnd128(); blk_ks[i] = rnd128(); end
        run_msg("hs_2a2c", h, ej0, model_tag(h, ej0, 2, 2), 2, 2, 1'b1, 1'b1);

        // Reset in the middle of a ciphertext multiply
        blk_data[0] = rnd128(); blk_ks[0] = rnd128();
        i_h = rnd128(); i_encrypted_j0 = rnd128(); i_tag = rnd128();
        i_aad_blocks = 16'd0; i_ct_blocks = 16'd1;
        i_start = 1'b1; step(); i_start = 1'b0;
        i_valid = 1'b1; i_data = blk_data[0]; i_keystream = blk_ks[0];
        step(); i_valid = 1'b0;
        for (int i = 0; i < 60; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst.ready", o_ready, 1'b0);
        chk("midrst.valid", o_valid, 1'b0);
        chk("midrst.pt", o_plain_text, 128'd0);
        chk("midrst.busy", o_busy, 1'b0);
        chk("midrst.done", o_done, 1'b0);
        chk("midrst.tag_ok", o_tag_ok, 1'b0);
        #1 rst = 1'b0;
        step();

        blk_data[0] = TC2_C; blk_ks[0] = TC2_C;
        run_msg("tc2_after_rst", NIST_H, NIST_EJ0, TC2_TAG, 0, 1, 1'b1, 1'b0);
        run_msg("tc2_b2b", NIST_H, NIST_EJ0, TC2_TAG, 0, 1, 1'b1, 1'b0);

        for (int m = 0; m < 8; m++) begin
            na = $urandom_range(0, 3);
            nc = $urandom_range(0, 3);
            flip = 1'($urandom_range(0, 1));
            h = rnd128(); ej0 = rnd128();
            for (int i = 0; i < na + nc; i++) begin blk_data[i] = rnd128(); blk_ks[i] = rnd128(); end
            t = model_tag(h, ej0, na, nc);
            if (flip) t ^= (128'd1 << $urandom_range(0, 127));
            run_msg($sformatf("rnd%0d", m), h, ej0, t, na, nc, !flip, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gcm_decrypt_verify.md
# gcm_decrypt_verify

Receive-side companion to the AES-GCM encrypt pipeline. It takes the keystream blocks (encrypted counter blocks), the hash subkey H and E(K,J0) produced by the AES stages, and uses them to decrypt ciphertext blocks and authenticate AAD and ciphertext with a bit-serial GHASH. It then compares the computed tag against the received tag. It sits after the last AES pipeline stage and consumes one 128-bit block per handshake.

## Interface
Parameters: none. Width 128 is fixed; bit 0 is the MSB, GCM bit order.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin a message; honoured only in IDLE or DONE
- i_h  in  128  hash subkey H, latched on accepted i_start
- i_encrypted_j0  in  128  E(K,J0), latched on accepted i_start
- i_tag  in  128  received tag, latched on accepted i_start
- i_aad_blocks  in  16  number of full 128-bit AAD blocks, latched on start
- i_ct_blocks  in  16  number of full 128-bit ciphertext blocks, latched on start
- i_valid  in  1  i_data / i_keystream valid
- o_ready  out  1  block accept allowed; transfer occurs when i_valid && o_ready at a rising edge
- i_data  in  128  AAD block, then ciphertext block
- i_keystream  in  128  E(K,CBi) for ciphertext blocks; ignored for AAD blocks
- o_valid  out  1  one-cycle pulse, o_plain_text valid
- o_plain_text  out  128  i_data XOR i_keystream, registered
- o_busy  out  1  high in all states except IDLE and DONE
- o_done  out  1  high while in DONE
- o_tag_ok  out  1  valid while o_done; 1 when the computed tag equals i_tag

## Operation
State machine states are IDLE, WAIT_BLK, MULT, LEN, FINAL and DONE.
- **IDLE/DONE, on i_start:**
  - Latch H, E(K,J0), the tag and both block counts.
  - Clear the accumulator Y to 0.
  - Go to WAIT_BLK if aad+ct > 0; otherwise go to LEN.
- **WAIT_BLK:** o_ready=1. On a transfer:
  - The first aad_blocks transfers are AAD. The rest are ciphertext.
  - For a ciphertext block, register o_plain_text = i_data ^ i_keystream and pulse o_valid.
  - GHASH input is always i_data (the ciphertext, never the plaintext).
  - Load X = Y ^ i_data, Z = 0, V = H, and counter = 0. Go to MULT.
- **MULT:** runs 128 iterations, one per cycle, for i = 0..127:
  - if X[i], then Z ^= V.
  - V = V[127] ? ({1'b0,V[0:126]} ^ 128'hE1000000_00000000_00000000_00000000) : {1'b0,V[0:126]}.
  - On the final iteration, Y = resulting Z.
  - Then go to WAIT_BLK if blocks remain, else LEN.
- **LEN:**
  - Form X = Y ^ {aad_blocks*128 as 64 bits, ct_blocks*128 as 64 bits}. Counts are zero-extended before the multiply by 128 (<<7).
  - Run the same 128-cycle multiply through MULT. On completion, go to FINAL.
- **FINAL:** computed tag = Y ^ E(K,J0). Register o_tag_ok = (computed tag == i_tag), then go to DONE.
- **DONE:** o_done=1 and outputs hold until the next accepted i_start or rst.

Boundary conditions:
- i_start outside IDLE/DONE is ignored.
- i_valid while o_ready=0 is ignored; nothing is buffered.
- There is no backpressure on o_plain_text.
- AAD and ciphertext blocks share one input stream, with no gap required between them.
- Zero AAD and/or zero ciphertext blocks are legal.

## Timing
- **Reset:** rst asserted at any time, including mid-MULT, forces the following immediately: IDLE, o_ready=0, o_valid=0, o_plain_text=0, o_busy=0, o_done=0, o_tag_ok=0, and Y, Z, V, X, the counters and all latched registers = 0.
- **Plaintext latency:** o_valid and o_plain_text appear the cycle after the accepting edge.
- **Block throughput:**
  - Accept at edge E0. MULT iterations occur on edges E1..E128.
  - o_ready=1 again after E128, so the next accept can occur at E129.
  - Throughput is 1 block per 129 cycles.
- **o_ready** is 0 in every state except WAIT_BLK.
- **Message latency:** after the last block accept at E0, LEN is entered after E128. The LEN multiply completes at E257, FINAL at E258, and DONE/o_tag_ok are visible after E259.
  - For a zero-block message, start at E0 gives DONE after E131 (LEN at E1, multiply E2..E129, FINAL E130, DONE E131).

## Test plan
- **NIST GCM TC1 (zero blocks):** H=66e94bd4ef8a2c3b884cfa59ca342b2e, EJ0=58e2fccefa7e3061367f1d57a4e7455a, tag=58e2fccefa7e3061367f1d57a4e7455a, aad=0, ct=0. Required: o_done with o_tag_ok=1, and no o_valid.
- **NIST TC2:** same H and EJ0, ct=1, data=0388dace60b6a392f328c2b971b2fe78, keystream=0388dace60b6a392f328c2b971b2fe78, tag=ab6e47d42cec13bdf53a67b21257bddf. Required: o_plain_text=0 with one o_valid pulse the cycle after accept, then o_tag_ok=1.
- **TC2 with tag bit 127 flipped:** required o_done=1 and o_tag_ok=0. Plaintext is still output.
- **Handshake and timing:** hold i_valid high continuously across 2 AAD + 2 ct blocks. Required:
  - Exactly 4 transfers, spaced 129 cycles apart.
  - Exactly 2 o_valid pulses.
  - o_ready low throughout MULT.
  - i_start pulses during busy are ignored.
- **Reset mid-multiply:** assert rst at MULT iteration 60. Required:
  - All outputs go 0 within the same cycle, with no clock edge.
  - A subsequent TC2 run passes cleanly.
- **Back-to-back messages:** i_start in DONE immediately restarts. Required: Y cleared, and the second message's tag verifies independently of the first.
